controller_sequencer: RTL and testbench



---
 rtl/sap_pkg.sv | 59 +++++
 rtl/controller_sequencer_if.sv | 36 +++
 rtl/ring_counter.sv | 37 +++
 rtl/controller_sequencer.sv | 98 +++++++++
 tb/tb_controller_sequencer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot T-state codes and control-word bit
// positions used by the sequencer, its wiring and any bench that decodes the word.
package sap_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int unsigned T_WIDTH = 6;
  localparam logic [T_WIDTH-1:0] T_HALT = 6'b000000;
  localparam logic [T_WIDTH-1:0] T1     = 6'b000001;
  localparam logic [T_WIDTH-1:0] T2     = 6'b000010;
  localparam logic [T_WIDTH-1:0] T3     = 6'b000100;
  localparam logic [T_WIDTH-1:0] T4     = 6'b001000;
  localparam logic [T_WIDTH-1:0] T5     = 6'b010000;
  localparam logic [T_WIDTH-1:0] T6     = 6'b100000;

  localparam int unsigned CW_WIDTH = 12;
  localparam int unsigned CW_CP = 0;   // PC increment
  localparam int unsigned CW_EP = 1;   // PC onto bus
  localparam int unsigned CW_LM = 2;   // MAR load
  localparam int unsigned CW_CE = 3;   // RAM onto bus
  localparam int unsigned CW_LI = 4;   // IR load
  localparam int unsigned CW_EI = 5;   // IR operand onto bus
  localparam int unsigned CW_LA = 6;   // A load
  localparam int unsigned CW_EA = 7;   // A onto bus
  localparam int unsigned CW_SU = 8;   // ALU subtract
  localparam int unsigned CW_EU = 9;   // ALU onto bus
  localparam int unsigned CW_LB = 10;  // B load
  localparam int unsigned CW_LO = 11;  // output register load

  typedef logic [CW_WIDTH-1:0] ctrl_word_t;

  typedef enum logic [2:0] {
    INS_LDA,
    INS_ADD,
    INS_SUB,
    INS_OUT,
    INS_HLT,
    INS_NOP
  } instr_e;

  // Unlisted opcodes fall through to NOP so execute cycles stay silent.
  function automatic instr_e decode_op(input logic [3:0] op);
    instr_e ins;
    case (op)
      OP_LDA:  ins = INS_LDA;
      OP_ADD:  ins = INS_ADD;
      OP_SUB:  ins = INS_SUB;
      OP_OUT:  ins = INS_OUT;
      OP_HLT:  ins = INS_HLT;
      default: ins = INS_NOP;
    endcase
    return ins;
  endfunction

endpackage

// File: rtl/controller_sequencer_if.sv
// Control-side bundle of the SAP-1 sequencer: run/opcode in, T-state, halt
// status and every bus strobe out.
interface controller_sequencer_if;
  logic       i_run;
  logic [3:0] i_opcode;
  logic [5:0] o_t_state;
  logic       o_halted;
  logic       o_pc_increment;
  logic       o_pc_enable_out;
  logic       o_mar_enable_in;
  logic       o_ram_enable_out;
  logic       o_ir_load;
  logic       o_ir_enable_out;
  logic       o_a_load;
  logic       o_a_enable_out;
  logic       o_alu_subtract;
  logic       o_alu_enable_out;
  logic       o_b_load;
  logic       o_out_load;

  modport slave (
    input  i_run, i_opcode,
    output o_t_state, o_halted,
    output o_pc_increment, o_pc_enable_out, o_mar_enable_in, o_ram_enable_out,
    output o_ir_load, o_ir_enable_out, o_a_load, o_a_enable_out,
    output o_alu_subtract, o_alu_enable_out, o_b_load, o_out_load
  );

  modport master (
    output i_run, i_opcode,
    input  o_t_state, o_halted,
    input  o_pc_increment, o_pc_enable_out, o_mar_enable_in, o_ram_enable_out,
    input  o_ir_load, o_ir_enable_out, o_a_load, o_a_enable_out,
    input  o_alu_subtract, o_alu_enable_out, o_b_load, o_out_load
  );
endinterface

// File: rtl/ring_counter.sv
// Six-bit one-hot T-state ring. Clearing to zero parks it in HALT, which is
// absorbing because rotating an all-zero ring leaves it all-zero.
module ring_counter
  import sap_pkg::*;
(
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_advance,
  input  logic               i_halt,
  output logic [T_WIDTH-1:0] o_ring
);

  logic [T_WIDTH-1:0] ring_d;
  logic [T_WIDTH-1:0] ring_q;

  // NOTE: defaulting ring_d to ring_q before any branch keeps this block free of latches.
  always_comb begin
    ring_d = ring_q;
    if (i_halt) begin
      ring_d = T_HALT;
    end else if (i_advance) begin
      ring_d = {ring_q[T_WIDTH-2:0], ring_q[T_WIDTH-1]};
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop sees pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ring_q <= T1;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign o_ring = ring_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: T-state ring plus microcode decode producing the control
// word for the PC, MAR, RAM, IR, A, B, ALU and output register.
module controller_sequencer
  import sap_pkg::*;
(
  input  logic                    i_clock,
  input  logic                    i_reset,
  controller_sequencer_if.slave   bus
);

  logic [T_WIDTH-1:0] ring;
  logic               halt_entry;
  instr_e             instr;
  ctrl_word_t         cw;

  assign instr = decode_op(bus.i_opcode);

  // HLT has no T5: the enabled edge that would end T4 clears the ring instead.
  assign halt_entry = bus.i_run && (ring == T4) && (instr == INS_HLT);

  ring_counter u_ring (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_advance (bus.i_run),
    .i_halt    (halt_entry),
    .o_ring    (ring)
  );

  always_comb begin
    cw = '0;
    if (!i_reset) begin
      case (ring)
        T1: begin
          cw[CW_EP] = 1'b1;
          cw[CW_LM] = 1'b1;
        end
        T2: cw[CW_CP] = 1'b1;
        T3: begin
          cw[CW_CE] = 1'b1;
          cw[CW_LI] = 1'b1;
        end
        T4: begin
          case (instr)
            INS_LDA, INS_ADD, INS_SUB: begin
              cw[CW_EI] = 1'b1;
              cw[CW_LM] = 1'b1;
            end
            INS_OUT: begin
              cw[CW_EA] = 1'b1;
              cw[CW_LO] = 1'b1;
            end
            default: cw = '0;
          endcase
        end
        T5: begin
          case (instr)
            INS_LDA: begin
              cw[CW_CE] = 1'b1;
              cw[CW_LA] = 1'b1;
            end
            INS_ADD, INS_SUB: begin
              cw[CW_CE] = 1'b1;
              cw[CW_LB] = 1'b1;
              cw[CW_SU] = (instr == INS_SUB);
            end
            default: cw = '0;
          endcase
        end
        T6: begin
          if (instr == INS_ADD || instr == INS_SUB) begin
            cw[CW_EU] = 1'b1;
            cw[CW_LA] = 1'b1;
            cw[CW_SU] = (instr == INS_SUB);
          end
        end
        default: cw = '0;
      endcase
    end
  end

  // During reset the T-state reads T1 even before the ring has been loaded.
  assign bus.o_t_state = i_reset ? T1 : ring;
  assign bus.o_halted  = !i_reset && (ring == T_HALT);

  assign bus.o_pc_increment   = cw[CW_CP];
  assign bus.o_pc_enable_out  = cw[CW_EP];
  assign bus.o_mar_enable_in  = cw[CW_LM];
  assign bus.o_ram_enable_out = cw[CW_CE];
  assign bus.o_ir_load        = cw[CW_LI];
  assign bus.o_ir_enable_out  = cw[CW_EI];
  assign bus.o_a_load         = cw[CW_LA];
  assign bus.o_a_enable_out   = cw[CW_EA];
  assign bus.o_alu_subtract   = cw[CW_SU];
  assign bus.o_alu_enable_out = cw[CW_EU];
  assign bus.o_b_load         = cw[CW_LB];
  assign bus.o_out_load       = cw[CW_LO];

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: each driven cycle pushes the
// expected T-state, halt flag and control word; the negedge sample pops and compares.
module tb_controller_sequencer;
  import sap_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controller_sequencer_if bus_if ();

  controller_sequencer dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_if)
  );

  typedef struct {
    string      tag;
    logic [5:0] t_state;
    logic       halted;
    logic [11:0] cw;
  } exp_s;

  exp_s sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_t;  // model T-state: 1..6, 0 = halted

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Expected control word, written straight from the microcode table.
  function automatic logic [11:0] model_cw(input int t, input logic [3:0] op);
    logic [11:0] w;
    w = '0;
    case (t)
      1: begin w[CW_EP] = 1'b1; w[CW_LM] = 1'b1; end
      2: w[CW_CP] = 1'b1;
      3: begin w[CW_CE] = 1'b1; w[CW_LI] = 1'b1; end
      4: begin
        if (op == 4'b0000 || op == 4'b0001 || op == 4'b0010) begin
          w[CW_EI] = 1'b1; w[CW_LM] = 1'b1;
        end else if (op == 4'b1110) begin
          w[CW_EA] = 1'b1; w[CW_LO] = 1'b1;
        end
      end
      5: begin
        if (op == 4'b0000) begin
          w[CW_CE] = 1'b1; w[CW_LA] = 1'b1;
        end else if (op == 4'b0001) begin
          w[CW_CE] = 1'b1; w[CW_LB] = 1'b1;
        end else if (op == 4'b0010) begin
          w[CW_CE] = 1'b1; w[CW_LB] = 1'b1; w[CW_SU] = 1'b1;
        end
      end
      6: begin
        if (op == 4'b0001) begin
          w[CW_EU] = 1'b1; w[CW_LA] = 1'b1;
        end else if (op == 4'b0010) begin
          w[CW_EU] = 1'b1; w[CW_LA] = 1'b1; w[CW_SU] = 1'b1;
        end
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [11:0] dut_cw();
    logic [11:0] w;
    w = '0;
    w[CW_CP] = bus_if.o_pc_increment;
    w[CW_EP] = bus_if.o_pc_enable_out;
    w[CW_LM] = bus_if.o_mar_enable_in;
    w[CW_CE] = bus_if.o_ram_enable_out;
    w[CW_LI] = bus_if.o_ir_load;
    w[CW_EI] = bus_if.o_ir_enable_out;
    w[CW_LA] = bus_if.o_a_load;
    w[CW_EA] = bus_if.o_a_enable_out;
    w[CW_SU] = bus_if.o_alu_subtract;
    w[CW_EU] = bus_if.o_alu_enable_out;
    w[CW_LB] = bus_if.o_b_load;
    w[CW_LO] = bus_if.o_out_load;
    return w;
  endfunction

  // One clock: drive, push expectation, sample at negedge, advance model at posedge.
  task automatic cycle(input string tag, input logic run, input logic reset, input logic [3:0] op);
    exp_s e;
    exp_s got_e;
    int   drivers;
    rst             = reset;
    bus_if.i_run    = run;
    bus_if.i_opcode = op;
    e.tag = tag;
    if (reset) begin
      e.t_state = 6'b000001;
      e.halted  = 1'b0;
      e.cw      = '0;
    end else begin
      e.t_state = (m_t == 0) ? 6'b000000 : 6'(1 << (m_t - 1));
      e.halted  = (m_t == 0);
      e.cw      = model_cw(m_t, op);
    end
    sb.push_back(e);

    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, ".scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      got_e = sb.pop_front();
      check({got_e.tag, ".t_state"}, 32'(bus_if.o_t_state), 32'(got_e.t_state));
      check({got_e.tag, ".halted"},  32'(bus_if.o_halted),  32'(got_e.halted));
      check({got_e.tag, ".cw"},      32'(dut_cw()),         32'(got_e.cw));
      drivers = int'(bus_if.o_pc_enable_out) + int'(bus_if.o_ram_enable_out) +
                int'(bus_if.o_ir_enable_out) + int'(bus_if.o_a_enable_out) +
                int'(bus_if.o_alu_enable_out);
      check({got_e.tag, ".one_driver"}, 32'(drivers <= 1), 32'd1);
    end

    @(posedge clk);
    if (reset) begin
      m_t = 1;
    end else if (m_t != 0 && run) begin
      if (m_t == 4 && op == 4'b1111) m_t = 0;
      else m_t = (m_t == 6) ? 1 : m_t + 1;
    end
    #1;
  endtask

  initial begin
    logic [3:0] ops [5];
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b1110; ops[4] = 4'b0111;

    rst             = 1'b1;
    bus_if.i_run    = 1'b0;
    bus_if.i_opcode = 4'b0000;
    m_t             = 1;
    @(posedge clk);
    #1;

    cycle("reset", 1'b0, 1'b1, 4'b0000);
    cycle("reset_run", 1'b1, 1'b1, 4'b0000);

    for (int i = 0; i < 6; i++) cycle("lda", 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 6; i++) cycle("sub", 1'b1, 1'b0, 4'b0010);
    for (int i = 0; i < 6; i++) cycle("undef", 1'b1, 1'b0, 4'b0111);
    for (int i = 0; i < 6; i++) cycle("out", 1'b1, 1'b0, 4'b1110);

    // Pause in T3: state and CE+Li hold, then advance to T4.
    for (int i = 0; i < 2; i++) cycle("pause_fetch", 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) cycle("pause_t3", 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) cycle("pause_resume", 1'b1, 1'b0, 4'b0000);

    // Reset in T5 of ADD abandons the instruction.
    for (int i = 0; i < 4; i++) cycle("add_pre", 1'b1, 1'b0, 4'b0001);
    cycle("add_t5_reset", 1'b1, 1'b1, 4'b0001);
    for (int i = 0; i < 6; i++) cycle("add_after", 1'b1, 1'b0, 4'b0001);

    // HLT: four enabled clocks to HALT, then absorbing regardless of run/opcode.
    for (int i = 0; i < 4; i++) cycle("hlt_fetch", 1'b1, 1'b0, 4'b1111);
    for (int i = 0; i < 20; i++) cycle("halted", 1'b1, 1'b0, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 2; i++) cycle("halted_norun", 1'b0, 1'b0, 4'b0000);
    cycle("halt_reset", 1'b1, 1'b1, 4'b1111);
    cycle("post_halt_t1", 1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 6; i++) cycle("post_halt_add", 1'b1, 1'b0, 4'b0001);

    // Mixed opcodes with random pauses.
    for (int i = 0; i < 40; i++) begin
      cycle("mix", 1'($urandom_range(0, 3) != 0), 1'b0, ops[$urandom_range(0, 4)]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
